ajuste_write_sched: RTL and testbench
=====================================

# ajuste_write_sched

Write scheduler that commits the user-adjusted time (hours, minutes, seconds, AM/PM) to the external RTC over a request/acknowledge register-write port. It sits between the clock-adjust datapath and the RTC bus interface. When the user leaves time-adjust mode, it snapshots the adjusted values, converts them to BCD and issues three ordered register writes. It also handles ack timeout, a commit that arrives while busy, and range clamping.

## Interface
Parameters:
- ACK_TIMEOUT, 255: cycles `wr_req` may stay high without `wr_ack` before the transfer is aborted; range 1..255.
- ADDR_SEG, 8'h21: RTC address of the seconds register.
- ADDR_MIN, 8'h22: RTC address of the minutes register.
- ADDR_HORA, 8'h23: RTC address of the hours register.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- sw_hora  in  1  time-adjust switch, already synchronised; a 1→0 transition means commit.
- cont_hora  in  4  adjusted hour, 1..12.
- cont_min  in  6  adjusted minutes, 0..59.
- cont_seg  in  6  adjusted seconds, 0..59.
- am_pm  in  1  0 = AM, 1 = PM.
- wr_req  out  1  write request to the RTC bus interface.
- wr_addr  out  8  register address; stable while `wr_req` = 1.
- wr_data  out  8  BCD data; stable while `wr_req` = 1.
- wr_ack  in  1  write accepted; sampled only while `wr_req` = 1.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the third write is acknowledged.
- err  out  1  sticky timeout flag; cleared when the next sequence starts.

## Operation
- Reset values: `wr_req`, `busy`, `done`, `err` = 0; `wr_addr`, `wr_data` = 8'h00; state = IDLE; pending = 0; `sw_hora` delay register = 0.
- Commit detection: a delay register holds the previous `sw_hora`. `commit` = `sw_hora_d` & ~`sw_hora`.
- States and transitions:
  - IDLE: on `commit` → LOAD.
  - LOAD: snapshot the inputs into BCD registers, clear `err`, field index = 0 → REQ.
  - REQ: `wr_req` = 1.
    - On `wr_ack` → GAP. Index 2 goes to DONE instead.
    - On timeout → IDLE with `err` = 1. Pending is discarded.
  - GAP: one cycle with `wr_req` = 0, index + 1 → REQ.
  - DONE: `done` = 1 for one cycle. Then → LOAD if pending (pending cleared), else → IDLE.
- Write order, fixed:
  1. `ADDR_SEG` / seconds BCD.
  2. `ADDR_MIN` / minutes BCD.
  3. `ADDR_HORA` / {`am_pm`, 2'b00, hour BCD[4:0]}.
- BCD conversion: tens = v / 10, units = v % 10, packed as {1'b0, tens[2:0], units[3:0]}. Hours use tens[0] only.
- Snapshot: the data is captured in LOAD only. Input changes during a sequence have no effect on it.
- Commit while not IDLE: sets pending. Multiple commits collapse into one pending re-run.
- `busy` = 1 in every state except IDLE.
- Reset mid-sequence: all outputs return to reset values immediately, asynchronously. No partial write is retried.
- `wr_ack` while `wr_req` = 0 is ignored.

## Timing
- `commit` sampled at edge k → LOAD at k → `wr_req` high after edge k+1.
- Per write: `wr_req` high from REQ entry until the edge that samples `wr_ack` = 1. `wr_req` is low for exactly one cycle between writes.
- With `wr_ack` tied high, the full sequence is 7 cycles from LOAD entry to `done`:
  - LOAD 1 cycle.
  - REQ/GAP/REQ/GAP/REQ 5 cycles.
  - DONE 1 cycle.
- Timeout: the counter clears on REQ entry and increments each REQ cycle without ack. At count = `ACK_TIMEOUT`, that edge drops `wr_req` and sets `err`.
- `done` is registered and high for exactly one cycle.

## Configuration
- `AJUSTE_CLAMP_EN` defined: values are clamped during LOAD.
  - `cont_seg`/`cont_min` > 59 → 59.
  - `cont_hora` = 0 → 12.
  - `cont_hora` > 12 → 12.
- `AJUSTE_CLAMP_EN` undefined: raw values are converted. 63 → 8'h63, hour 0 → 5'h00, hour 15 → 5'h15.

## Test plan
- Basic commit: hora = 7, min = 45, seg = 30, am_pm = 1, `sw_hora` 1→0, `wr_ack` tied high → writes (21,30), (22,45), (23,87); `done` 7 cycles after LOAD; `err` = 0.
- Delayed ack: ack 3 cycles after each request → `wr_addr`/`wr_data` stable throughout; one idle `wr_req` cycle between writes; `done` once.
- Timeout: `ACK_TIMEOUT` = 4, `wr_ack` = 0 → `wr_req` drops after 4 cycles; `err` = 1; `busy` = 0; only address 21 was presented.
- Commit while busy: second `sw_hora` 1→0 during write 2 with inputs changed to min = 10 → first sequence completes with old values; second sequence writes min 8'h10.
- Reset mid-sequence: `rst` = 0 during REQ for address 22 → `wr_req`, `busy` = 0 asynchronously; after release, no write without a new commit.
- Clamp: min = 62, hora = 0 → with `AJUSTE_CLAMP_EN`: 8'h59, hour byte 8'h12; without it: 8'h62, hour byte 8'h00.

Source files
------------

// File: rtl/ajuste_write_sched.sv
// ajuste_write_sched: commits the user-adjusted time to the RTC.
// A falling edge on sw_hora snapshots hour/min/sec/AM-PM, converts them to
// BCD and issues three ordered request/acknowledge register writes
// (seconds, minutes, hours). Handles ack timeout and commits arriving while busy.
// Optional build macro: AJUSTE_CLAMP_EN clamps out-of-range values at snapshot time.
//
// state  | meaning
// IDLE   | waiting for a commit
// LOAD   | snapshot inputs into BCD registers, clear err
// REQ    | wr_req high for field idx, waiting for wr_ack or timeout
// GAP    | one idle cycle between writes
// DONE   | done pulse, re-run if a commit arrived meanwhile
module ajuste_write_sched #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [7:0]  ADDR_SEG    = 8'h21,
  parameter logic [7:0]  ADDR_MIN    = 8'h22,
  parameter logic [7:0]  ADDR_HORA   = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_hora,
  input  logic [3:0] cont_hora,
  input  logic [5:0] cont_min,
  input  logic [5:0] cont_seg,
  input  logic       am_pm,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_GAP, S_DONE} state_t;

  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       sw_hora_q;
  logic [7:0] seg_bcd_q, seg_bcd_d;
  logic [7:0] min_bcd_q, min_bcd_d;
  logic [7:0] hora_byte_q, hora_byte_d;
  logic       commit;
  logic [5:0] seg_eff, min_eff;
  logic [3:0] hora_eff;

  function automatic logic [7:0] bcd_byte(input logic [5:0] v);
    logic [2:0] tens;
    logic [3:0] units;
    tens  = 3'(v / 6'd10);
    units = 4'(v % 6'd10);
    return {1'b0, tens, units};
  endfunction

  // Hours are at most 15, so a single tens bit is enough.
  function automatic logic [4:0] bcd_hora(input logic [3:0] v);
    logic       tens;
    logic [3:0] units;
    tens  = 1'(v / 4'd10);
    units = 4'(v % 4'd10);
    return {tens, units};
  endfunction

  assign commit = sw_hora_q & ~sw_hora;

  // Values presented to the snapshot, optionally clamped to the legal range.
  always_comb begin
`ifdef AJUSTE_CLAMP_EN
    seg_eff  = (cont_seg > 6'd59) ? 6'd59 : cont_seg;
    min_eff  = (cont_min > 6'd59) ? 6'd59 : cont_min;
    hora_eff = ((cont_hora == 4'd0) || (cont_hora > 4'd12)) ? 4'd12 : cont_hora;
`else
    seg_eff  = cont_seg;
    min_eff  = cont_min;
    hora_eff = cont_hora;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      sw_hora_q   <= 1'b0;
      seg_bcd_q   <= 8'h00;
      min_bcd_q   <= 8'h00;
      hora_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      sw_hora_q   <= sw_hora;
      seg_bcd_q   <= seg_bcd_d;
      min_bcd_q   <= min_bcd_d;
      hora_byte_q <= hora_byte_d;
    end
  end

  // Next-state logic: sequencing, ack timeout, pending re-run and snapshot.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    err_d       = err_q;
    seg_bcd_d   = seg_bcd_q;
    min_bcd_d   = min_bcd_q;
    hora_byte_d = hora_byte_q;

    if (commit && (state_q != S_IDLE)) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        seg_bcd_d   = bcd_byte(seg_eff);
        min_bcd_d   = bcd_byte(min_eff);
        hora_byte_d = {am_pm, 2'b00, bcd_hora(hora_eff)};
        err_d       = 1'b0;
        idx_d       = 2'd0;
        cnt_d       = 8'd0;
        state_d     = S_REQ;
      end
      S_REQ: begin
        if (wr_ack) begin
          cnt_d   = 8'd0;
          state_d = (idx_q == 2'd2) ? S_DONE : S_GAP;
        end else if ((cnt_q + 8'd1) == ACK_LIMIT) begin
          // Abort: the whole sequence is dropped, including any queued re-run.
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        idx_d   = idx_q + 2'd1;
        cnt_d   = 8'd0;
        state_d = S_REQ;
      end
      S_DONE: begin
        // A commit landing on the DONE cycle itself joins the pending re-run.
        if (pend_q || commit) begin
          pend_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; address/data held while wr_req is high.
  always_comb begin
    wr_req  = (state_q == S_REQ);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    err     = err_q;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    if (state_q == S_REQ) begin
      case (idx_q)
        2'd0: begin
          wr_addr = ADDR_SEG;
          wr_data = seg_bcd_q;
        end
        2'd1: begin
          wr_addr = ADDR_MIN;
          wr_data = min_bcd_q;
        end
        default: begin
          wr_addr = ADDR_HORA;
          wr_data = hora_byte_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ajuste_write_sched.sv
// Self-checking bench for ajuste_write_sched (ACK_TIMEOUT = 4).
// A negedge monitor acts as the RTC bus: it acks after a programmable number
// of request cycles and logs every presented/accepted write.
module tb_ajuste_write_sched;

  logic       clk;
  logic       rst;
  logic       sw_hora;
  logic [3:0] cont_hora;
  logic [5:0] cont_min;
  logic [5:0] cont_seg;
  logic       am_pm;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  ajuste_write_sched #(
    .ACK_TIMEOUT(4),
    .ADDR_SEG   (8'h21),
    .ADDR_MIN   (8'h22),
    .ADDR_HORA  (8'h23)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_hora  (sw_hora),
    .cont_hora(cont_hora),
    .cont_min (cont_min),
    .cont_seg (cont_seg),
    .am_pm    (am_pm),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_ms(input int v);
    int x;
    x = v;
`ifdef AJUSTE_CLAMP_EN
    if (x > 59) x = 59;
`endif
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [7:0] m_hr(input int h, input int pm);
    int x;
    x = h;
`ifdef AJUSTE_CLAMP_EN
    if (x == 0 || x > 12) x = 12;
`endif
    return 8'(pm * 128 + ((x / 10) % 2) * 16 + (x % 10));
  endfunction

  logic [7:0] exp_a[$];
  logic [7:0] exp_d[$];

  task automatic push_exp(input int s, input int m, input int h, input int p);
    exp_a.push_back(8'h21); exp_d.push_back(m_ms(s));
    exp_a.push_back(8'h22); exp_d.push_back(m_ms(m));
    exp_a.push_back(8'h23); exp_d.push_back(m_hr(h, p));
  endtask

  // ---------------- bus responder / monitor ----------------
  int  ncyc = 0;
  int  ack_delay = 0;
  bit  ack_en = 1'b1;
  bit  ack_noise = 1'b0;
  int  req_len = 0;
  int  unstable = 0;
  logic [7:0] hold_a, hold_d;
  logic [7:0] a_q[$];
  logic [7:0] d_q[$];
  logic [7:0] pres_q[$];
  int acc_cyc_q[$];
  int rise_cyc_q[$];
  int len_q[$];
  int done_cyc_q[$];

  initial begin
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (done === 1'b1) done_cyc_q.push_back(ncyc);
      if (wr_req === 1'b1) begin
        if (req_len == 0) begin
          pres_q.push_back(wr_addr);
          rise_cyc_q.push_back(ncyc);
          hold_a = wr_addr;
          hold_d = wr_data;
        end else if (wr_addr !== hold_a || wr_data !== hold_d) begin
          unstable++;
        end
        req_len++;
        if (ack_en && req_len > ack_delay) begin
          wr_ack = 1'b1;
          a_q.push_back(wr_addr);
          d_q.push_back(wr_data);
          acc_cyc_q.push_back(ncyc);
        end else begin
          wr_ack = 1'b0;
        end
      end else begin
        if (req_len != 0) len_q.push_back(req_len);
        req_len = 0;
        wr_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic clear_mon();
    a_q.delete(); d_q.delete(); pres_q.delete();
    acc_cyc_q.delete(); rise_cyc_q.delete(); len_q.delete(); done_cyc_q.delete();
    exp_a.delete(); exp_d.delete();
    unstable = 0;
  endtask

  task automatic set_inputs(input int s, input int m, input int h, input int p);
    cont_seg  = 6'(s);
    cont_min  = 6'(m);
    cont_hora = 4'(h);
    am_pm     = 1'(p);
  endtask

  // Returns the negedge count after which the commit edge is sampled.
  task automatic do_commit(output int c);
    @(negedge clk); #1 sw_hora = 1'b1;
    @(negedge clk); #1 sw_hora = 1'b0;
    c = ncyc;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    sw_hora = 1'b0;
    set_inputs(0, 0, 12, 0);
    repeat (3) @(negedge clk);
    #1;
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL reset wr_req: got %b want 0", wr_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL reset wr_addr: got %h want 00", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset wr_data: got %h want 00", wr_data); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset idle_after_release busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int c;
    bit ok;
    ack_en = 1'b1; ack_delay = 0; ack_noise = 1'b0;
    clear_mon();
    set_inputs(30, 45, 7, 1);
    push_exp(30, 45, 7, 1);
    do_commit(c);
    wait_idle(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic idle: busy stuck, got %b want 0", busy); end
    total++; if (a_q.size() != 3) begin bad++; $display("FAIL basic count: got %0d want 3", a_q.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < a_q.size()) begin
        total++; if (a_q[i] !== exp_a[i]) begin bad++; $display("FAIL basic addr[%0d]: got %h want %h", i, a_q[i], exp_a[i]); end
        total++; if (d_q[i] !== exp_d[i]) begin bad++; $display("FAIL basic data[%0d]: got %h want %h", i, d_q[i], exp_d[i]); end
      end
    end
    total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL basic done_count: got %0d want 1", done_cyc_q.size()); end
    if (done_cyc_q.size() >= 1) begin
      total++; if (done_cyc_q[0] - c != 7) begin bad++; $display("FAIL basic done_latency: got %0d want 7", done_cyc_q[0] - c); end
    end
    if (rise_cyc_q.size() >= 1) begin
      total++; if (rise_cyc_q[0] - c != 2) begin bad++; $display("FAIL basic req_latency: got %0d want 2", rise_cyc_q[0] - c); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic err: got %b want 0", err); end
  endtask

  task automatic test_delayed_ack();
    int c, s, m, h, p;
    bit ok;
    ack_en = 1'b1; ack_delay = 3; ack_noise = 1'b1;
    clear_mon();
    s = $urandom_range(0, 59); m = $urandom_range(0, 59);
    h = $urandom_range(1, 12); p = $urandom_range(0, 1);
    set_inputs(s, m, h, p);
    push_exp(s, m, h, p);
    do_commit(c);
    wait_idle(80, ok);
    ack_noise = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL delayed idle: busy stuck, got %b want 0", busy); end
    total++; if (a_q.size() != 3) begin bad++; $display("FAIL delayed count: got %0d want 3", a_q.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < a_q.size()) begin
        total++; if (a_q[i] !== exp_a[i]) begin bad++; $display("FAIL delayed addr[%0d]: got %h want %h", i, a_q[i], exp_a[i]); end
        total++; if (d_q[i] !== exp_d[i]) begin bad++; $display("FAIL delayed data[%0d]: got %h want %h", i, d_q[i], exp_d[i]); end
      end
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL delayed stability: got %0d changes want 0", unstable); end
    for (int i = 1; i < 3; i++) begin
      if (i < rise_cyc_q.size() && i - 1 < acc_cyc_q.size()) begin
        total++;
        if (rise_cyc_q[i] - acc_cyc_q[i-1] != 2) begin
          bad++; $display("FAIL delayed gap[%0d]: got %0d idle cycles want 1", i, rise_cyc_q[i] - acc_cyc_q[i-1] - 1);
        end
      end
    end
    for (int i = 0; i < len_q.size(); i++) begin
      total++; if (len_q[i] != 4) begin bad++; $display("FAIL delayed req_len[%0d]: got %0d want 4", i, len_q[i]); end
    end
    total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL delayed done_count: got %0d want 1", done_cyc_q.size()); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL delayed err: got %b want 0", err); end
  endtask

  task automatic test_timeout();
    int c;
    bit ok;
    ack_en = 1'b0; ack_noise = 1'b0;
    clear_mon();
    set_inputs(11, 22, 3, 0);
    do_commit(c);
    wait_idle(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout idle: busy stuck, got %b want 0", busy); end
    total++; if (pres_q.size() != 1) begin bad++; $display("FAIL timeout presented: got %0d want 1", pres_q.size()); end
    if (pres_q.size() >= 1) begin
      total++; if (pres_q[0] !== 8'h21) begin bad++; $display("FAIL timeout addr: got %h want 21", pres_q[0]); end
    end
    if (len_q.size() >= 1) begin
      total++; if (len_q[0] != 4) begin bad++; $display("FAIL timeout req_len: got %0d want 4", len_q[0]); end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout err: got %b want 1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout busy: got %b want 0", busy); end
    total++; if (done_cyc_q.size() != 0) begin bad++; $display("FAIL timeout done_count: got %0d want 0", done_cyc_q.size()); end
    repeat (5) @(negedge clk);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout err_sticky: got %b want 1", err); end
    ack_en = 1'b1;
  endtask

  task automatic test_commit_busy();
    int c, c2;
    bit ok;
    ack_en = 1'b1; ack_delay = 2; ack_noise = 1'b0;
    clear_mon();
    set_inputs(5, 20, 3, 0);
    push_exp(5, 20, 3, 0);
    do_commit(c);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pres_q.size() >= 2) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL busy write2: got %0d presented want 2", pres_q.size()); end
    cont_min = 6'd10;
    push_exp(5, 10, 3, 0);
    do_commit(c2);
    do_commit(c2);
    wait_idle(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy idle: busy stuck, got %b want 0", busy); end
    total++; if (a_q.size() != 6) begin bad++; $display("FAIL busy count: got %0d want 6", a_q.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < a_q.size()) begin
        total++; if (a_q[i] !== exp_a[i]) begin bad++; $display("FAIL busy addr[%0d]: got %h want %h", i, a_q[i], exp_a[i]); end
        total++; if (d_q[i] !== exp_d[i]) begin bad++; $display("FAIL busy data[%0d]: got %h want %h", i, d_q[i], exp_d[i]); end
      end
    end
    total++; if (done_cyc_q.size() != 2) begin bad++; $display("FAIL busy done_count: got %0d want 2", done_cyc_q.size()); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL busy err_cleared: got %b want 0", err); end
  endtask

  task automatic test_clamp();
    int c;
    bit ok;
    logic [7:0] want_min, want_hr;
`ifdef AJUSTE_CLAMP_EN
    want_min = 8'h59; want_hr = 8'h12;
`else
    want_min = 8'h62; want_hr = 8'h00;
`endif
    ack_en = 1'b1; ack_delay = 0; ack_noise = 1'b0;
    clear_mon();
    set_inputs(59, 62, 0, 0);
    do_commit(c);
    wait_idle(60, ok);
    total++; if (a_q.size() != 3) begin bad++; $display("FAIL clamp count: got %0d want 3", a_q.size()); end
    if (a_q.size() == 3) begin
      total++; if (d_q[0] !== 8'h59) begin bad++; $display("FAIL clamp seg59: got %h want 59", d_q[0]); end
      total++; if (d_q[1] !== want_min) begin bad++; $display("FAIL clamp min: got %h want %h", d_q[1], want_min); end
      total++; if (d_q[2] !== want_hr) begin bad++; $display("FAIL clamp hour: got %h want %h", d_q[2], want_hr); end
    end
  endtask

  task automatic test_random();
    int c, s, m, h, p;
    bit ok;
    ack_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      clear_mon();
      ack_delay = $urandom_range(0, 3);
      ack_noise = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 63); m = $urandom_range(0, 63);
      h = $urandom_range(0, 15); p = $urandom_range(0, 1);
      set_inputs(s, m, h, p);
      push_exp(s, m, h, p);
      do_commit(c);
      wait_idle(80, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d idle: busy stuck, got %b want 0", it, busy); end
      total++; if (a_q.size() != 3) begin bad++; $display("FAIL rand%0d count: got %0d want 3", it, a_q.size()); end
      for (int i = 0; i < exp_a.size(); i++) begin
        if (i < a_q.size()) begin
          total++; if (a_q[i] !== exp_a[i]) begin bad++; $display("FAIL rand%0d addr[%0d]: got %h want %h", it, i, a_q[i], exp_a[i]); end
          total++; if (d_q[i] !== exp_d[i]) begin bad++; $display("FAIL rand%0d data[%0d]: got %h want %h", it, i, d_q[i], exp_d[i]); end
        end
      end
      total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL rand%0d done_count: got %0d want 1", it, done_cyc_q.size()); end
    end
    ack_noise = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c;
    bit ok;
    ack_en = 1'b1; ack_delay = 3; ack_noise = 1'b0;
    clear_mon();
    set_inputs(12, 34, 9, 1);
    do_commit(c);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pres_q.size() >= 2) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid reach22: got %0d presented want 2", pres_q.size()); end
    total++; if (wr_addr !== 8'h22) begin bad++; $display("FAIL rstmid addr_before: got %h want 22", wr_addr); end
    #1 rst = 1'b0;
    #1;
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL rstmid wr_req_async: got %b want 0", wr_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid busy_async: got %b want 0", busy); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL rstmid wr_addr_async: got %h want 00", wr_addr); end
    @(negedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total++; if (pres_q.size() != 2) begin bad++; $display("FAIL rstmid no_retry: got %0d presented want 2", pres_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid busy_after: got %b want 0", busy); end
    total++; if (a_q.size() != 1) begin bad++; $display("FAIL rstmid accepted: got %0d want 1", a_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_timeout();
    test_commit_busy();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
